// File: rtl/axis_frame_pad_trunc.sv
// AXI-Stream byte frame length conditioner.
// Frames shorter than the pad target are extended with 0x00 beats.
// Frames longer than length_max are cut at length_max, and the rest of the
// input frame is accepted and discarded.
// A status pulse with pad/trunc flags and the saturating in/out beat counts
// is produced once per completed frame.
// Optional build macro AXIS_FRAME_PAD_TRUNC_MARK_EN: forces m_axis_tuser[0]=1
// on the last output beat of a truncated frame.
//
// state | meaning
// XFER  | pass input beats through, detect pad / truncate conditions
// PAD   | emit 0x00 filler beats until the pad target is reached
// DROP  | swallow the remainder of a truncated input frame
module axis_frame_pad_trunc #(
   parameter int LEN_WIDTH  = 16,
   parameter int USER_WIDTH = 1
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic [7:0]            s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,

   output logic [7:0]            m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,

   input  logic [LEN_WIDTH-1:0]  length_min,
   input  logic [LEN_WIDTH-1:0]  length_max,

   output logic                  status_valid,
   output logic                  status_frame_pad,
   output logic                  status_frame_trunc,
   output logic [LEN_WIDTH-1:0]  status_len_in,
   output logic [LEN_WIDTH-1:0]  status_len_out
);

   typedef enum logic [1:0] {
      XFER = 2'd0,
      PAD  = 2'd1,
      DROP = 2'd2
   } state_t;

   localparam logic [LEN_WIDTH-1:0] CNT_SAT = '1;
   localparam logic [LEN_WIDTH-1:0] CNT_ONE = LEN_WIDTH'(1);
   localparam logic [LEN_WIDTH:0]   WIDE_ONE = (LEN_WIDTH+1)'(1);

   state_t                  state_q, state_d;
   logic [LEN_WIDTH-1:0]    cnt_in_q, cnt_in_d;
   logic [LEN_WIDTH-1:0]    cnt_out_q, cnt_out_d;
   logic [LEN_WIDTH-1:0]    lim_min_q, lim_min_d;
   logic [LEN_WIDTH-1:0]    lim_max_q, lim_max_d;
   logic                    pad_q, pad_d;
   logic                    trunc_q, trunc_d;
   logic [USER_WIDTH-1:0]   user_cap_q, user_cap_d;

   logic [7:0]              out_data_q, out_data_d;
   logic                    out_valid_q, out_valid_d;
   logic                    out_last_q, out_last_d;
   logic [USER_WIDTH-1:0]   out_user_q, out_user_d;

   logic                    st_valid_q, st_valid_d;
   logic                    st_pad_q, st_pad_d;
   logic                    st_trunc_q, st_trunc_d;
   logic [LEN_WIDTH-1:0]    st_len_in_q, st_len_in_d;
   logic [LEN_WIDTH-1:0]    st_len_out_q, st_len_out_d;

   logic                    load_en;
   logic                    first_beat;
   logic [LEN_WIDTH-1:0]    eff_min, eff_max, pad_tgt;
   logic [LEN_WIDTH-1:0]    cnt_in_inc, cnt_out_inc;
   logic [LEN_WIDTH:0]      cnt_out_p1;
   logic                    at_max, below_tgt;
   logic                    accept;

   // Output register may take a new beat when empty or being drained.
   assign load_en = !out_valid_q || m_axis_tready;

   // Limits come straight from the inputs on the first beat, from the held copy after.
   assign first_beat = (state_q == XFER) && (cnt_in_q == '0);
   assign eff_min    = first_beat ? length_min : lim_min_q;
   assign eff_max    = first_beat ? length_max : lim_max_q;
   assign pad_tgt    = ((eff_max != '0) && (eff_max < eff_min)) ? eff_max : eff_min;

   // Saturating increments; the wide compare value never wraps.
   assign cnt_in_inc  = (cnt_in_q  == CNT_SAT) ? cnt_in_q  : cnt_in_q  + CNT_ONE;
   assign cnt_out_inc = (cnt_out_q == CNT_SAT) ? cnt_out_q : cnt_out_q + CNT_ONE;
   assign cnt_out_p1  = {1'b0, cnt_out_q} + WIDE_ONE;
   assign at_max      = (eff_max != '0) && (cnt_out_p1 == {1'b0, eff_max});
   assign below_tgt   = cnt_out_p1 < {1'b0, pad_tgt};

   assign s_axis_tready = !rst && ((state_q == DROP) || ((state_q == XFER) && load_en));
   assign accept        = s_axis_tvalid && s_axis_tready;

   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_valid_q;
   assign m_axis_tlast  = out_last_q;
   assign m_axis_tuser  = out_user_q;

   assign status_valid       = st_valid_q;
   assign status_frame_pad   = st_pad_q;
   assign status_frame_trunc = st_trunc_q;
   assign status_len_in      = st_len_in_q;
   assign status_len_out     = st_len_out_q;

   // Next-state, output register and status computation.
   always_comb begin
      state_d      = state_q;
      cnt_in_d     = cnt_in_q;
      cnt_out_d    = cnt_out_q;
      lim_min_d    = lim_min_q;
      lim_max_d    = lim_max_q;
      pad_d        = pad_q;
      trunc_d      = trunc_q;
      user_cap_d   = user_cap_q;
      out_data_d   = out_data_q;
      out_valid_d  = out_valid_q;
      out_last_d   = out_last_q;
      out_user_d   = out_user_q;
      st_valid_d   = 1'b0;
      st_pad_d     = st_pad_q;
      st_trunc_d   = st_trunc_q;
      st_len_in_d  = st_len_in_q;
      st_len_out_d = st_len_out_q;

      if (load_en) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         XFER: begin
            if (accept) begin
               if (first_beat) begin
                  lim_min_d = length_min;
                  lim_max_d = length_max;
               end
               out_valid_d = 1'b1;
               out_data_d  = s_axis_tdata;
               out_user_d  = s_axis_tuser;
               cnt_in_d    = cnt_in_inc;
               cnt_out_d   = cnt_out_inc;
               if (s_axis_tlast && below_tgt) begin
                  out_last_d = 1'b0;
                  user_cap_d = s_axis_tuser;
                  pad_d      = 1'b1;
                  state_d    = PAD;
               end else if (s_axis_tlast) begin
                  // A limit hit coinciding with tlast is an ordinary frame end.
                  out_last_d   = 1'b1;
                  st_valid_d   = 1'b1;
                  st_pad_d     = 1'b0;
                  st_trunc_d   = 1'b0;
                  st_len_in_d  = cnt_in_inc;
                  st_len_out_d = cnt_out_inc;
                  cnt_in_d     = '0;
                  cnt_out_d    = '0;
                  pad_d        = 1'b0;
                  trunc_d      = 1'b0;
               end else if (at_max) begin
                  out_last_d = 1'b1;
                  trunc_d    = 1'b1;
                  state_d    = DROP;
`ifdef AXIS_FRAME_PAD_TRUNC_MARK_EN
                  out_user_d[0] = 1'b1;
`endif
               end else begin
                  out_last_d = 1'b0;
               end
            end
         end

         PAD: begin
            if (load_en) begin
               out_valid_d = 1'b1;
               out_data_d  = 8'h00;
               out_user_d  = user_cap_q;
               cnt_out_d   = cnt_out_inc;
               if (!below_tgt) begin
                  out_last_d   = 1'b1;
                  st_valid_d   = 1'b1;
                  st_pad_d     = 1'b1;
                  st_trunc_d   = trunc_q;
                  st_len_in_d  = cnt_in_q;
                  st_len_out_d = cnt_out_inc;
                  cnt_in_d     = '0;
                  cnt_out_d    = '0;
                  pad_d        = 1'b0;
                  trunc_d      = 1'b0;
                  state_d      = XFER;
               end else begin
                  out_last_d = 1'b0;
               end
            end
         end

         DROP: begin
            if (accept) begin
               cnt_in_d = cnt_in_inc;
               if (s_axis_tlast) begin
                  st_valid_d   = 1'b1;
                  st_pad_d     = pad_q;
                  st_trunc_d   = 1'b1;
                  st_len_in_d  = cnt_in_inc;
                  st_len_out_d = cnt_out_q;
                  cnt_in_d     = '0;
                  cnt_out_d    = '0;
                  pad_d        = 1'b0;
                  trunc_d      = 1'b0;
                  state_d      = XFER;
               end
            end
         end

         default: begin
            state_d = XFER;
         end
      endcase
   end

   // State, counters, output register and status register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= XFER;
         cnt_in_q     <= '0;
         cnt_out_q    <= '0;
         lim_min_q    <= '0;
         lim_max_q    <= '0;
         pad_q        <= 1'b0;
         trunc_q      <= 1'b0;
         user_cap_q   <= '0;
         out_data_q   <= 8'h00;
         out_valid_q  <= 1'b0;
         out_last_q   <= 1'b0;
         out_user_q   <= '0;
         st_valid_q   <= 1'b0;
         st_pad_q     <= 1'b0;
         st_trunc_q   <= 1'b0;
         st_len_in_q  <= '0;
         st_len_out_q <= '0;
      end else begin
         state_q      <= state_d;
         cnt_in_q     <= cnt_in_d;
         cnt_out_q    <= cnt_out_d;
         lim_min_q    <= lim_min_d;
         lim_max_q    <= lim_max_d;
         pad_q        <= pad_d;
         trunc_q      <= trunc_d;
         user_cap_q   <= user_cap_d;
         out_data_q   <= out_data_d;
         out_valid_q  <= out_valid_d;
         out_last_q   <= out_last_d;
         out_user_q   <= out_user_d;
         st_valid_q   <= st_valid_d;
         st_pad_q     <= st_pad_d;
         st_trunc_q   <= st_trunc_d;
         st_len_in_q  <= st_len_in_d;
         st_len_out_q <= st_len_out_d;
      end
   end

endmodule

// File: tb/tb_axis_frame_pad_trunc.sv
// Scoreboard bench for axis_frame_pad_trunc: directed pad/trunc/boundary
// frames, reset in the middle of padding, then randomized handshakes.
module tb_axis_frame_pad_trunc;

   localparam int LW = 16;
   localparam int UW = 1;

   typedef struct packed {
      logic [7:0] d;
      logic       l;
      logic       u;
   } beat_t;

   typedef struct packed {
      logic          p;
      logic          t;
      logic [LW-1:0] li;
      logic [LW-1:0] lo;
   } stat_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [7:0]    s_axis_tdata = 8'h00;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic          s_axis_tlast = 1'b0;
   logic [UW-1:0] s_axis_tuser = '0;
   logic [7:0]    m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic [UW-1:0] m_axis_tuser;
   logic [LW-1:0] length_min = '0;
   logic [LW-1:0] length_max = '0;
   logic          status_valid;
   logic          status_frame_pad;
   logic          status_frame_trunc;
   logic [LW-1:0] status_len_in;
   logic [LW-1:0] status_len_out;

   int    checks = 0;
   int    errors = 0;
   int    beat_cnt = 0;
   bit    sb_en = 1'b1;
   bit    rnd_ready = 1'b0;
   bit    rnd_valid = 1'b0;
   beat_t exp_q[$];
   stat_t st_q[$];
   bit    hold_pending = 1'b0;
   beat_t held;

   axis_frame_pad_trunc #(.LEN_WIDTH(LW), .USER_WIDTH(UW)) dut (
      .clk                (clk),
      .rst                (rst),
      .s_axis_tdata       (s_axis_tdata),
      .s_axis_tvalid      (s_axis_tvalid),
      .s_axis_tready      (s_axis_tready),
      .s_axis_tlast       (s_axis_tlast),
      .s_axis_tuser       (s_axis_tuser),
      .m_axis_tdata       (m_axis_tdata),
      .m_axis_tvalid      (m_axis_tvalid),
      .m_axis_tready      (m_axis_tready),
      .m_axis_tlast       (m_axis_tlast),
      .m_axis_tuser       (m_axis_tuser),
      .length_min         (length_min),
      .length_max         (length_max),
      .status_valid       (status_valid),
      .status_frame_pad   (status_frame_pad),
      .status_frame_trunc (status_frame_trunc),
      .status_len_in      (status_len_in),
      .status_len_out     (status_len_out)
   );

   always #5 clk = ~clk;

   initial begin
      #800000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // Output-side backpressure, changed just after each rising edge.
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rnd_ready ? 1'($urandom_range(1, 0)) : 1'b1;
      end
   end

   // Output monitor: scoreboard pops, status pops, hold stability.
   always @(negedge clk) begin
      beat_t obs;
      stat_t sobs;
      beat_t e;
      stat_t se;
      obs = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser[0]};
      if (hold_pending && !rst) begin
         checks++;
         assert (m_axis_tvalid === 1'b1 && obs === held) else begin
            errors++;
            $error("FAIL hold_stable observed=%b/%h expected=1/%h", m_axis_tvalid, obs, held);
         end
      end
      hold_pending = m_axis_tvalid && !m_axis_tready && !rst;
      held = obs;
      if (m_axis_tvalid && m_axis_tready && !rst) begin
         beat_cnt++;
         if (sb_en) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $error("FAIL beat_extra observed=%h expected=none", obs);
            end else begin
               e = exp_q.pop_front();
               assert (obs === e) else begin
                  errors++;
                  $error("FAIL beat observed=d%h l%b u%b expected=d%h l%b u%b", obs.d, obs.l, obs.u, e.d, e.l, e.u);
               end
            end
         end
      end
      if (status_valid && sb_en) begin
         sobs = '{p: status_frame_pad, t: status_frame_trunc, li: status_len_in, lo: status_len_out};
         checks++;
         if (st_q.size() == 0) begin
            errors++;
            $error("FAIL status_extra observed=%h expected=none", sobs);
         end else begin
            se = st_q.pop_front();
            assert (sobs === se) else begin
               errors++;
               $error("FAIL status observed=p%b t%b in%0d out%0d expected=p%b t%b in%0d out%0d", sobs.p, sobs.t, sobs.li, sobs.lo, se.p, se.t, se.li, se.lo);
            end
         end
      end
   end

   // Build expected output for one frame, then drive its input beats.
   task automatic send_frame(input int len, input int mn, input int mx, input bit rnd_user);
      logic [7:0] fd[0:255];
      logic       fu[0:255];
      int         tgt;
      for (int i = 0; i < len; i++) begin
         fd[i] = 8'($urandom_range(255, 0));
         fu[i] = rnd_user ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      tgt = (mx != 0 && mx < mn) ? mx : mn;
      if (mx != 0 && len > mx) begin
         for (int i = 0; i < mx; i++) begin
`ifdef AXIS_FRAME_PAD_TRUNC_MARK_EN
            exp_q.push_back('{d: fd[i], l: (i == mx - 1), u: (i == mx - 1) ? 1'b1 : fu[i]});
`else
            exp_q.push_back('{d: fd[i], l: (i == mx - 1), u: fu[i]});
`endif
         end
         st_q.push_back('{p: 1'b0, t: 1'b1, li: LW'(len), lo: LW'(mx)});
      end else if (len < tgt) begin
         for (int i = 0; i < len; i++) exp_q.push_back('{d: fd[i], l: 1'b0, u: fu[i]});
         for (int i = len; i < tgt; i++) exp_q.push_back('{d: 8'h00, l: (i == tgt - 1), u: fu[len-1]});
         st_q.push_back('{p: 1'b1, t: 1'b0, li: LW'(len), lo: LW'(tgt)});
      end else begin
         for (int i = 0; i < len; i++) exp_q.push_back('{d: fd[i], l: (i == len - 1), u: fu[i]});
         st_q.push_back('{p: 1'b0, t: 1'b0, li: LW'(len), lo: LW'(len)});
      end
      length_min = LW'(mn);
      length_max = LW'(mx);
      for (int i = 0; i < len; i++) begin
         if (rnd_valid) begin
            while ($urandom_range(1, 0) == 1) begin
               s_axis_tvalid = 1'b0;
               @(posedge clk);
               #1;
            end
         end
         s_axis_tvalid = 1'b1;
         s_axis_tdata  = fd[i];
         s_axis_tlast  = (i == len - 1);
         s_axis_tuser  = fu[i];
         forever begin
            @(negedge clk);
            if (s_axis_tready) break;
         end
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic drain();
      while (exp_q.size() != 0 || st_q.size() != 0) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
   endtask

   initial begin
      int mn, mx, len;
      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      assert (m_axis_tvalid === 1'b0) else begin errors++; $error("FAIL rst_tvalid observed=%b expected=0", m_axis_tvalid); end
      checks++;
      assert (s_axis_tready === 1'b0) else begin errors++; $error("FAIL rst_tready observed=%b expected=0", s_axis_tready); end
      checks++;
      assert (status_valid === 1'b0) else begin errors++; $error("FAIL rst_status observed=%b expected=0", status_valid); end
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Padding, truncation, boundaries, clamped pad target, tiny frames.
      send_frame(10, 60, 1518, 1'b1);
      drain();
      send_frame(100, 0, 64, 1'b0);
      drain();
      send_frame(60, 60, 0, 1'b1);
      drain();
      send_frame(64, 0, 64, 1'b1);
      drain();
      send_frame(5, 20, 10, 1'b1);
      drain();
      send_frame(1, 1, 0, 1'b1);
      send_frame(1, 0, 0, 1'b1);
      send_frame(3, 4, 1, 1'b1);
      drain();

      // Reset in the middle of padding.
      sb_en = 1'b0;
      beat_cnt = 0;
      send_frame(10, 60, 1518, 1'b0);
      while (beat_cnt < 30) @(posedge clk);
      #1;
      rst = 1'b1;
      @(negedge clk);
      checks++;
      assert (s_axis_tready === 1'b0) else begin errors++; $error("FAIL midrst_tready observed=%b expected=0", s_axis_tready); end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      checks++;
      assert (m_axis_tvalid === 1'b0) else begin errors++; $error("FAIL midrst_tvalid observed=%b expected=0", m_axis_tvalid); end
      checks++;
      assert (status_valid === 1'b0) else begin errors++; $error("FAIL midrst_status observed=%b expected=0", status_valid); end
      exp_q.delete();
      st_q.delete();
      sb_en = 1'b1;
      @(posedge clk);
      #1;
      send_frame(70, 60, 1518, 1'b1);
      drain();

      // Randomized handshakes on both sides.
      rnd_ready = 1'b1;
      rnd_valid = 1'b1;
      for (int f = 0; f < 1000; f++) begin
         len = $urandom_range(12, 1);
         mn  = $urandom_range(10, 0);
         mx  = ($urandom_range(1, 0) == 1) ? 0 : $urandom_range(12, 1);
         send_frame(len, mn, mx, 1'b1);
      end
      drain();
      rnd_ready = 1'b0;
      repeat (2) @(posedge clk);

      checks++;
      assert (exp_q.size() == 0 && st_q.size() == 0) else begin
         errors++;
         $error("FAIL leftover observed=%0d/%0d expected=0/0", exp_q.size(), st_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
